// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-requester memory arbiter.
//   state_t : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE).
//   req_t   : captured request (we, addr, wdata, misaligned). addr/wdata are
//             sized to the widest supported bus; the top zero-extends into them,
//             so ADDR_WIDTH and DATA_WIDTH must not exceed PKG_MAX_AW/PKG_MAX_DW.
package mem_arbiter_pkg;

   localparam int unsigned PKG_MAX_AW = 64;
   localparam int unsigned PKG_MAX_DW = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [PKG_MAX_AW-1:0] addr;
      logic [PKG_MAX_DW-1:0] wdata;
      logic                  misaligned;
   } req_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: 2-way round-robin grant.
//   i_valid[1:0]  : request valid bits (bit N = requester N).
//   i_last_grant  : index granted most recently.
//   o_gnt_vld     : some requester is granted this cycle.
//   o_gnt_idx     : granted requester index.
// A lone requester always wins; on conflict the one not granted last wins.
module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] i_valid,
   input  logic       i_last_grant,
   output logic       o_gnt_vld,
   output logic       o_gnt_idx
);

   assign o_gnt_vld = |i_valid;
   assign o_gnt_idx = (&i_valid) ? ~i_last_grant : (i_valid[1] & ~i_valid[0]);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a core (req0) and a loader/DMA (req1) onto one
// single-port synchronous memory. One transaction every three cycles:
// accept in IDLE, strobe memory in ACCESS, return the response in RESP.
//   clk, reset                      : clock, async active-high reset.
//   reqN_valid/ready/we/addr/wdata  : requester N handshake and payload.
//   rspN_valid/rdata/err            : one-cycle response to requester N.
//   mem_addr/wdata/w_en/read_en     : memory command (word address).
//   mem_rdata                       : memory read data, one cycle after read.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_AW     = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp0_err,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  rsp1_err,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_w_en,
   output logic                  mem_read_en,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_t r_state, w_next;
   req_t   r_req, w_req;
   logic   r_idx;
   logic   r_last_grant;
   logic   w_gnt_vld, w_gnt_idx, w_accept;
   logic   w_rsp, w_good_load;
   logic   w_unused;

   rr_arbiter2 u_rr (
      .i_valid      ({req1_valid, req0_valid}),
      .i_last_grant (r_last_grant),
      .o_gnt_vld    (w_gnt_vld),
      .o_gnt_idx    (w_gnt_idx)
   );

   // Requests are only looked at in IDLE; inputs in other states are ignored.
   assign w_accept   = (r_state == IDLE) && w_gnt_vld;
   assign req0_ready = w_accept && !w_gnt_idx;
   assign req1_ready = w_accept &&  w_gnt_idx;

   // Capture mux for the granted requester, zero-extended into req_t.
   always_comb begin
      w_req = '0;
      if (w_gnt_idx) begin
         w_req.we                   = req1_we;
         w_req.addr[ADDR_WIDTH-1:0] = req1_addr;
         w_req.wdata[DATA_WIDTH-1:0] = req1_wdata;
         w_req.misaligned           = |req1_addr[1:0];
      end else begin
         w_req.we                   = req0_we;
         w_req.addr[ADDR_WIDTH-1:0] = req0_addr;
         w_req.wdata[DATA_WIDTH-1:0] = req0_wdata;
         w_req.misaligned           = |req0_addr[1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;   // req0 wins the first conflict
         r_idx        <= 1'b0;
         r_req        <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_idx        <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_req        <= w_req;
         end
      end
   end

   // Strobes and responses decode straight from the state register, so an
   // async reset in ACCESS/RESP removes them in the same instant.
   always_comb begin
      w_next      = r_state;
      mem_w_en    = 1'b0;
      mem_read_en = 1'b0;
      w_rsp       = 1'b0;
      case (r_state)
         IDLE:   if (w_gnt_vld) w_next = ACCESS;
         ACCESS: begin
            w_next      = RESP;
            mem_w_en    =  r_req.we && !r_req.misaligned;
            mem_read_en = !r_req.we && !r_req.misaligned;
         end
         RESP: begin
            w_next = IDLE;
            w_rsp  = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   // Upper address bits above MEM_AW+2 are dropped: addresses wrap silently.
   assign mem_addr  = r_req.addr[MEM_AW+1:2];
   assign mem_wdata = r_req.wdata[DATA_WIDTH-1:0];

   assign w_good_load = !r_req.we && !r_req.misaligned;
   assign rsp0_valid  = w_rsp && !r_idx;
   assign rsp1_valid  = w_rsp &&  r_idx;
   assign rsp0_err    = rsp0_valid && r_req.misaligned;
   assign rsp1_err    = rsp1_valid && r_req.misaligned;
   assign rsp0_rdata  = (rsp0_valid && w_good_load) ? mem_rdata : '0;
   assign rsp1_rdata  = (rsp1_valid && w_good_load) ? mem_rdata : '0;

   // Padding bits of the wide request struct are intentionally dropped.
   assign w_unused = ^r_req;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int MAW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req0_ready, req0_we;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          rsp0_valid, rsp0_err;
   logic [DW-1:0] rsp0_rdata;
   logic          req1_valid, req1_ready, req1_we;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          rsp1_valid, rsp1_err;
   logic [DW-1:0] rsp1_rdata;
   logic [MAW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_w_en, mem_read_en;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
      .mem_read_en(mem_read_en), .mem_rdata(mem_rdata)
   );

   // Advance to 2 time units after the next rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      mem_rdata = 32'h5A5A_5A5A;
      reset = 1'b1;
      #13;
      checks++; if ({mem_w_en, mem_read_en} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_w_en, mem_read_en}); end
      checks++; if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 4'b0) begin failures++; $display("FAIL reset_rsp got=%b exp=0000", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}); end
      checks++; if ({rsp0_rdata, rsp1_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {rsp0_rdata, rsp1_rdata}); end
      checks++; if ({mem_addr, mem_wdata} !== '0) begin failures++; $display("FAIL reset_memcmd got=%h/%h exp=0/0", mem_addr, mem_wdata); end
      // ready follows valid in IDLE even while reset is held
      req1_valid = 1; #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b10) begin failures++; $display("FAIL reset_ready got=%b exp=10", {req1_ready, req0_ready}); end
      req1_valid = 0;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_store();
      mem_rdata = 32'hCAFE_F00D;
      req0_valid = 1; req0_we = 1; req0_addr = 32'h10; req0_wdata = 32'hDEAD_BEEF;
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL store_ready got=%b exp=01", {req1_ready, req0_ready}); end
      step();
      idle_inputs();
      #1;
      checks++; if ({mem_w_en, mem_read_en} !== 2'b10) begin failures++; $display("FAIL store_strobe got=%b exp=10", {mem_w_en, mem_read_en}); end
      checks++; if (mem_addr !== 10'd4) begin failures++; $display("FAIL store_addr got=%h exp=4", mem_addr); end
      checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_wdata got=%h exp=deadbeef", mem_wdata); end
      checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL store_early_rsp got=%b exp=0", rsp0_valid); end
      step();
      checks++; if ({rsp1_valid, rsp0_valid, rsp0_err} !== 3'b010) begin failures++; $display("FAIL store_rsp got=%b exp=010", {rsp1_valid, rsp0_valid, rsp0_err}); end
      checks++; if (rsp0_rdata !== 32'h0) begin failures++; $display("FAIL store_rdata got=%h exp=0", rsp0_rdata); end
      checks++; if ({mem_w_en, mem_read_en} !== 2'b00) begin failures++; $display("FAIL store_strobe_off got=%b exp=00", {mem_w_en, mem_read_en}); end
      step();
      checks++; if (rsp0_valid !== 1'b0 || mem_addr !== 10'd4) begin failures++; $display("FAIL store_after got=%b/%h exp=0/4", rsp0_valid, mem_addr); end
   endtask

   task automatic test_load();
      mem_rdata = 32'hDEAD_BEEF;
      req1_valid = 1; req1_we = 0; req1_addr = 32'h10;
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b10) begin failures++; $display("FAIL load_ready got=%b exp=10", {req1_ready, req0_ready}); end
      step();
      idle_inputs();
      #1;
      checks++; if ({mem_w_en, mem_read_en, mem_addr} !== {2'b01, 10'd4}) begin failures++; $display("FAIL load_strobe got=%b/%h exp=01/4", {mem_w_en, mem_read_en}, mem_addr); end
      step();
      checks++; if ({rsp1_valid, rsp0_valid, rsp1_err} !== 3'b100) begin failures++; $display("FAIL load_rsp got=%b exp=100", {rsp1_valid, rsp0_valid, rsp1_err}); end
      checks++; if (rsp1_rdata !== 32'hDEAD_BEEF || rsp0_rdata !== 32'h0) begin failures++; $display("FAIL load_rdata got=%h/%h exp=deadbeef/0", rsp1_rdata, rsp0_rdata); end
      step();
   endtask

   task automatic test_misaligned();
      mem_rdata = 32'hDEAD_BEEF;
      req0_valid = 1; req0_we = 0; req0_addr = 32'h13;
      step();
      idle_inputs();
      #1;
      checks++; if ({mem_w_en, mem_read_en} !== 2'b00) begin failures++; $display("FAIL mis_strobe got=%b exp=00", {mem_w_en, mem_read_en}); end
      step();
      checks++; if ({rsp0_valid, rsp0_err, rsp1_valid} !== 3'b110) begin failures++; $display("FAIL mis_rsp got=%b exp=110", {rsp0_valid, rsp0_err, rsp1_valid}); end
      checks++; if (rsp0_rdata !== 32'h0) begin failures++; $display("FAIL mis_rdata got=%h exp=0", rsp0_rdata); end
      step();
   endtask

   task automatic test_wrap();
      // 0xFFFFF00C >> 2 = 0x3FFFFC03, low 10 bits = 0x003
      req1_valid = 1; req1_we = 1; req1_addr = 32'hFFFF_F00C; req1_wdata = 32'h0BAD_CAFE;
      step();
      idle_inputs();
      #1;
      checks++; if ({mem_w_en, mem_addr} !== {1'b1, 10'h003}) begin failures++; $display("FAIL wrap_addr got=%b/%h exp=1/003", mem_w_en, mem_addr); end
      step();
      checks++; if ({rsp1_valid, rsp1_err} !== 2'b10) begin failures++; $display("FAIL wrap_rsp got=%b exp=10", {rsp1_valid, rsp1_err}); end
      step();
   endtask

   task automatic test_held_inputs();
      req0_valid = 1; req0_we = 0; req0_addr = 32'h20;
      step();
      req0_addr = 32'h40; req1_valid = 1; req1_we = 1; req1_addr = 32'h80;
      #1;
      checks++; if (mem_addr !== 10'd8 || mem_read_en !== 1'b1) begin failures++; $display("FAIL held_addr got=%h/%b exp=8/1", mem_addr, mem_read_en); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin failures++; $display("FAIL held_ready_access got=%b exp=00", {req1_ready, req0_ready}); end
      step();
      checks++; if ({req1_ready, req0_ready} !== 2'b00 || mem_addr !== 10'd8) begin failures++; $display("FAIL held_resp got=%b/%h exp=00/8", {req1_ready, req0_ready}, mem_addr); end
      idle_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_rdy, exp_rsp;
      logic       idx;
      reset = 1'b1;
      #3;
      reset = 1'b0;
      step();
      req0_valid = 1; req0_we = 1; req0_addr = 32'h100; req0_wdata = 32'h1111_1111;
      req1_valid = 1; req1_we = 1; req1_addr = 32'h200; req1_wdata = 32'h2222_2222;
      #1;
      for (int c = 0; c < 12; c++) begin
         if (c != 0) step();
         idx     = ((c / 3) % 2) == 1;
         exp_rdy = (c % 3 == 0) ? (idx ? 2'b10 : 2'b01) : 2'b00;
         exp_rsp = (c % 3 == 2) ? (idx ? 2'b10 : 2'b01) : 2'b00;
         checks++; if ({req1_ready, req0_ready} !== exp_rdy) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, {req1_ready, req0_ready}, exp_rdy); end
         checks++; if ({rsp1_valid, rsp0_valid} !== exp_rsp) begin failures++; $display("FAIL b2b_rsp c=%0d got=%b exp=%b", c, {rsp1_valid, rsp0_valid}, exp_rsp); end
         if (c % 3 == 1) begin
            checks++; if ({mem_w_en, mem_addr} !== {1'b1, idx ? 10'h080 : 10'h040}) begin failures++; $display("FAIL b2b_mem c=%0d got=%b/%h exp=1/%h", c, mem_w_en, mem_addr, idx ? 10'h080 : 10'h040); end
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_mid_reset();
      // req0 alone: last_grant becomes 0, so without reset req1 would win next
      req0_valid = 1; req0_we = 1; req0_addr = 32'h30; req0_wdata = 32'h3333_3333;
      step();
      idle_inputs();
      #1;
      checks++; if (mem_w_en !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", mem_w_en); end
      reset = 1'b1;
      #1;
      checks++; if ({mem_w_en, mem_read_en} !== 2'b00) begin failures++; $display("FAIL midrst_strobe got=%b exp=00", {mem_w_en, mem_read_en}); end
      step();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if ({rsp1_valid, rsp0_valid, mem_w_en, mem_read_en} !== 4'b0) begin failures++; $display("FAIL midrst_quiet c=%0d got=%b exp=0000", c, {rsp1_valid, rsp0_valid, mem_w_en, mem_read_en}); end
      end
      req0_valid = 1; req1_valid = 1; req0_we = 0; req1_we = 0;
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL midrst_grant got=%b exp=01", {req1_ready, req0_ready}); end
      step();
      idle_inputs();
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_misaligned();
      test_wrap();
      test_held_inputs();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning requester byte-address width.
REQ-003 The block SHALL have parameter MEM_AW, default 10, meaning word-address width on the memory side.
REQ-004 The block SHALL have these ports (name, direction, width, meaning); there is one clock, and reset is asynchronous and active-high:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- reqN_valid  in  1  request valid, N=0 (core), N=1 (loader/DMA).
- reqN_ready  out  1  request accepted when valid and ready are both high.
- reqN_we  in  1  1=store, 0=load.
- reqN_addr  in  ADDR_WIDTH  byte address.
- reqN_wdata  in  DATA_WIDTH  store data.
- rspN_valid  out  1  one-cycle response pulse.
- rspN_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
- rspN_err  out  1  misaligned-access flag, valid with rspN_valid.
- mem_addr  out  MEM_AW  word address = accepted byte address >> 2, truncated.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_w_en  out  1  write strobe.
- mem_read_en  out  1  read strobe.
- mem_rdata  in  DATA_WIDTH  synchronous read data, valid one cycle after mem_read_en.

Function
REQ-005 The FSM SHALL have three states, IDLE, ACCESS and RESP; IDLE SHALL go to ACCESS on accept, ACCESS SHALL go to RESP unconditionally, and RESP SHALL go to IDLE unconditionally.
REQ-006 req0_ready and req1_ready SHALL be combinational, high only in IDLE, and only for the requester selected by the grant logic; at most one SHALL be high per cycle.
REQ-007 Grant SHALL be round-robin: if only one requester is valid, it is granted; if both are valid, the requester not recorded in last_grant is granted.
REQ-008 On accept, the block SHALL register the granted index, we, addr, wdata and a misaligned flag (addr[1:0] != 0), and SHALL update last_grant.
REQ-009 In ACCESS, the block SHALL drive mem_addr and mem_wdata from the registered request, and SHALL assert mem_w_en (store) or mem_read_en (load) for exactly one cycle; neither strobe SHALL be asserted if the request is misaligned.
REQ-010 In RESP, the block SHALL assert rspN_valid for exactly one cycle for the registered index only; rspN_rdata SHALL equal mem_rdata for an aligned load and 0 otherwise, and rspN_err SHALL equal the misaligned flag.
REQ-011 Outside ACCESS, mem_w_en and mem_read_en SHALL be 0; mem_addr and mem_wdata SHALL hold their registered values.
REQ-012 Outside RESP, rspN_valid, rspN_rdata and rspN_err SHALL be 0.
REQ-013 Latency SHALL be accept at edge T, memory strobe during cycle T+1, response during cycle T+2; peak throughput SHALL be one transaction per 3 cycles.
REQ-014 The block SHALL ignore changes to reqN_valid or reqN_* inputs outside IDLE; requesters SHALL hold valid until ready is seen.
REQ-015 An address wider than MEM_AW+2 bits SHALL wrap modulo 2^MEM_AW words, with no error.

Reset
REQ-016 Reset SHALL asynchronously force the IDLE state, last_grant=1 (so req0 wins the first conflict), all registered request fields to 0, and all outputs to 0 except ready, which follows REQ-006.
REQ-017 Reset asserted in ACCESS or RESP SHALL abort the transaction with no memory strobe and no response after reset, and the aborted transaction SHALL NOT be retried.

Structure
REQ-018 A shared package SHALL hold the state enum (IDLE, ACCESS, RESP) and a request struct (we, addr, wdata, misaligned).
REQ-019 One sub-module, rr_arbiter2 (2-way round-robin grant from valid bits and last_grant), SHALL be instantiated; the FSM and datapath SHALL remain in mem_arbiter.

Verification
REQ-020 Aligned store: req0 store addr 0x10, data 0xDEADBEEF -> mem_w_en in cycle T+1 with mem_addr=4; rsp0_valid in cycle T+2 with rdata=0 and err=0.
REQ-021 Aligned load: req1 load 0x10 with mem_rdata=0xDEADBEEF -> mem_read_en in cycle T+1; rsp1_rdata=0xDEADBEEF in cycle T+2; rsp0_valid stays 0.
REQ-022 Contention: both requesters valid continuously, starting after reset -> grants 0,1,0,1, each 3 cycles apart.
REQ-023 Misaligned: req0 load 0x13 -> no mem strobe; rsp0_err=1 and rdata=0.
REQ-024 Mid-operation reset: assert reset during ACCESS -> strobe drops immediately, no rsp pulse, state IDLE; req0 wins the next conflict.
REQ-025 Held inputs: change req0_addr while in ACCESS -> mem_addr is unchanged.
